// File: rtl/seg7_mux_driver.sv
// Time-multiplexed driver for N common-anode 7-segment digits.
// The display shows a shadow copy of value/dp/blank_mask, which is captured on a load strobe.
// One digit is scanned per REFRESH_DIV-cycle slot.
// A PWM window at the start of each slot sets the brightness.
// Leading zeros can be suppressed, and individual digits can be blanked.
// Every pin output is registered, so the pins lag the scan state by one cycle.
//
// Handshake: load is a single-cycle strobe with no ready/ack. The shadow registers
// accept it on any edge, including while en=0 and on a slot boundary.
module seg7_mux_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       value,
  input  logic [N_DIGITS-1:0]         dp,
  input  logic [N_DIGITS-1:0]         blank_mask,
  input  logic                        lz_suppress,
  input  logic [BRIGHT_BITS-1:0]      brightness,
  output logic [6:0]                  seg,
  output logic                        dp_n,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int CW   = $clog2(REFRESH_DIV);
  localparam int OW   = CW + 1;
  localparam int STEP = REFRESH_DIV >> BRIGHT_BITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  logic [CW-1:0]          cnt;
  logic [4*N_DIGITS-1:0]  sh_value;
  logic [N_DIGITS-1:0]    sh_dp;
  logic [N_DIGITS-1:0]    sh_blank;
  logic [BRIGHT_BITS-1:0] bright_lat;

  logic [BRIGHT_BITS-1:0] bright_eff;
  logic [OW-1:0]          on_cycles;
  logic [N_DIGITS:0]      zero_from;
  logic [3:0]             nib;
  logic                   lz_hit;
  logic                   lit;
  logic [6:0]             nxt_seg;
  logic                   nxt_dp_n;
  logic [N_DIGITS-1:0]    nxt_an;

  // Active-low glyphs {g,f,e,d,c,b,a} for hex digits.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  // PWM window: at cnt=0 the live brightness is being latched, so it is used directly.
  // Any value gives on_cycles >= STEP, so cnt=0 is always lit regardless.
  always_comb begin
    bright_eff = (cnt == '0) ? brightness : bright_lat;
    on_cycles  = OW'((int'(bright_eff) + 1) * STEP);
  end

  // zero_from[i] = nibbles i..N_DIGITS-1 are all zero (leading-zero detection).
  always_comb begin
    zero_from           = '0;
    zero_from[N_DIGITS] = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (sh_value[4*i +: 4] == 4'h0);
    end
  end

  // Next pin values for the digit under scan, dark by default.
  always_comb begin
    nib      = sh_value[{digit_idx, 2'b00} +: 4];
    lz_hit   = lz_suppress && (digit_idx != '0) && zero_from[digit_idx];
    lit      = en && !sh_blank[digit_idx] && ({1'b0, cnt} < on_cycles);
    nxt_seg  = 7'h7F;
    nxt_dp_n = 1'b1;
    nxt_an   = '1;
    if (lit) begin
      if (lz_hit) begin
        // A suppressed digit keeps only its decimal point.
        if (sh_dp[digit_idx]) begin
          nxt_an   = ~(N_DIGITS'(1) << digit_idx);
          nxt_dp_n = 1'b0;
        end
      end else begin
        nxt_an   = ~(N_DIGITS'(1) << digit_idx);
        nxt_seg  = glyph(nib);
        nxt_dp_n = ~sh_dp[digit_idx];
      end
    end
  end

  // Slot counter and digit index; both are held at zero while scanning is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (!en) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers and brightness latch (brightness only changes at slot start).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      bright_lat <= '1;
    end else begin
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_blank <= blank_mask;
      end
      if (cnt == '0) bright_lat <= brightness;
    end
  end

  // Registered pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg  <= 7'h7F;
      dp_n <= 1'b1;
      an   <= '1;
    end else begin
      seg  <= nxt_seg;
      dp_n <= nxt_dp_n;
      an   <= nxt_an;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed testbench for seg7_mux_driver (N_DIGITS=4, REFRESH_DIV=8, BRIGHT_BITS=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_seg7_mux_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank_mask;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int n_checks = 0;
  int n_errors = 0;

  seg7_mux_driver #(.N_DIGITS(4), .REFRESH_DIV(8), .BRIGHT_BITS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp(dp),
    .blank_mask(blank_mask), .lz_suppress(lz_suppress), .brightness(brightness),
    .seg(seg), .dp_n(dp_n), .an(an), .digit_idx(digit_idx)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Capture value/dp/blank_mask with a one-cycle load strobe.
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank_mask = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // Resynchronise the scan: one disabled edge parks cnt/digit_idx at 0.
  // The next edge then shows digit 0 at cnt 0.
  task automatic restart();
    en = 1'b0;
    step();
    en = 1'b1;
  endtask

  // One 8-cycle slot at full brightness, with the same pins expected on every cycle.
  task automatic run_slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dpn);
    for (int c = 0; c < 8; c++) begin
      step();
      check({tag, "_an"}, an, e_an);
      check({tag, "_seg"}, seg, e_seg);
      check({tag, "_dpn"}, dp_n, e_dpn);
    end
  endtask

  logic [3:0] scan_an [4];
  logic [6:0] scan_seg[4];

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = '0; dp = '0; blank_mask = '0;
    lz_suppress = 1'b0; brightness = 2'd3;
    @(negedge clk);
    @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dpn", dp_n, 1'b1);
    check("rst_idx", digit_idx, 2'd0);
    rst = 1'b0;

    // Basic scan of 12AF at full brightness, with the wrap back to digit 0.
    do_load(16'h12AF, 4'b0000, 4'b0000);
    en = 1'b1;
    scan_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    scan_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
    for (int s = 0; s < 4; s++) begin
      run_slot($sformatf("scan%0d", s), scan_an[s], scan_seg[s], 1'b1);
    end
    step();
    check("wrap_an", an, 4'hE);
    check("wrap_seg", seg, 7'h0E);
    check("wrap_idx", digit_idx, 2'd0);

    // Asynchronous reset in the middle of the digit-2 slot.
    restart();
    steps(19);
    check("pre_rst_idx", digit_idx, 2'd2);
    check("pre_rst_an", an, 4'hB);
    #2 rst = 1'b1;
    #1;
    check("async_an", an, 4'hF);
    check("async_seg", seg, 7'h7F);
    check("async_dpn", dp_n, 1'b1);
    check("async_idx", digit_idx, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_an", an, 4'hE);
    check("post_rst_seg", seg, 7'h40);

    // Brightness 0: lit for cnt 0..1 only. A mid-slot change waits for the next slot start.
    do_load(16'h12AF, 4'b0000, 4'b0000);
    brightness = 2'd0;
    restart();
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("dim0_c%0d", c), an, (c < 2) ? 4'hE : 4'hF);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      check($sformatf("dim1_c%0d", c), an, (c < 2) ? 4'hD : 4'hF);
      if (c == 2) brightness = 2'd3;
    end
    run_slot("bright_full", 4'hB, 7'h24, 1'b1);

    // Leading-zero suppression; the suppressed digit 2 keeps its decimal point.
    lz_suppress = 1'b1;
    do_load(16'h0030, 4'b0100, 4'b0000);
    restart();
    run_slot("lz_d0", 4'hE, 7'h40, 1'b1);
    run_slot("lz_d1", 4'hD, 7'h30, 1'b1);
    run_slot("lz_d2", 4'hB, 7'h7F, 1'b0);
    run_slot("lz_d3", 4'hF, 7'h7F, 1'b1);
    do_load(16'h0000, 4'b0000, 4'b0000);
    restart();
    run_slot("lz0_d0", 4'hE, 7'h40, 1'b1);
    run_slot("lz0_d1", 4'hF, 7'h7F, 1'b1);
    run_slot("lz0_d2", 4'hF, 7'h7F, 1'b1);
    run_slot("lz0_d3", 4'hF, 7'h7F, 1'b1);
    lz_suppress = 1'b0;

    // Per-digit blanking.
    do_load(16'h5555, 4'b0000, 4'b0010);
    restart();
    run_slot("blk_d0", 4'hE, 7'h12, 1'b1);
    run_slot("blk_d1", 4'hF, 7'h7F, 1'b1);
    run_slot("blk_d2", 4'hB, 7'h12, 1'b1);
    run_slot("blk_d3", 4'h7, 7'h12, 1'b1);

    // Drop en in the digit-3 slot, load while disabled, and re-enable.
    // Then a load that coincides with a slot boundary.
    do_load(16'h5555, 4'b0000, 4'b0000);
    restart();
    steps(27);
    check("pre_dis_an", an, 4'h7);
    check("pre_dis_idx", digit_idx, 2'd3);
    en = 1'b0;
    step();
    check("dis_an", an, 4'hF);
    check("dis_seg", seg, 7'h7F);
    check("dis_dpn", dp_n, 1'b1);
    check("dis_idx", digit_idx, 2'd0);
    do_load(16'h7777, 4'b0000, 4'b0000);
    check("dis_load_an", an, 4'hF);
    en = 1'b1;
    step();
    check("reen_an", an, 4'hE);
    check("reen_seg", seg, 7'h78);
    steps(6);
    value = 16'h8888; load = 1'b1;
    step();
    load = 1'b0;
    check("bnd_old_an", an, 4'hE);
    check("bnd_old_seg", seg, 7'h78);
    step();
    check("bnd_new_an", an, 4'hD);
    check("bnd_new_seg", seg, 7'h00);
    check("bnd_new_idx", digit_idx, 2'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
